// File: rtl/cdc_pkg.sv
// Shared types and the round-robin pick helper for the req/ack CDC transmit side.
package cdc_pkg;

    localparam int RR_MAX = 8;

    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of valid[n-1:0] at or above ptr, wrapping at n. Requires ptr < n <= RR_MAX.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [2:0]        ptr,
                                         input int                n);
        rr_pick_t r;
        int       k;
        r = '0;
        // Scan from the far end so the nearest candidate is the last one written.
        for (int i = RR_MAX - 1; i >= 0; i--) begin
            if (i < n) begin
                k = int'(ptr) + i;
                if (k >= n) begin
                    k = k - n;
                end
                if (valid[k[2:0]]) begin
                    r.found = 1'b1;
                    r.idx   = k[2:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dual_ff_sync.sv
// Two-flop synchroniser for slow or toggle-encoded signals crossing into clk.
module dual_ff_sync #(
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Source-side controller for a toggle req/ack CDC channel shared round-robin by NUM_REQ producers.
// state    | meaning
// ARB_IDLE | channel free; grant the next valid requester, latch its word, toggle req
// ARB_WAIT | word held on xfer_data; waiting for synchronised ack to match req
module cdc_tx_arbiter
    import cdc_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            in_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    output logic [NUM_REQ-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]         xfer_data,
    output logic [$clog2(NUM_REQ)-1:0]    xfer_id,
    output logic                          xfer_req,
    input  logic                          xfer_ack,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NUM_REQ - 1);

    arb_state_t    state, state_nxt;
    logic [PW-1:0] rr_ptr;
    logic [TW-1:0] timer;
    logic          ack_s;
    logic          ack_match;
    logic          grant;
    logic [PW-1:0] g;
    rr_pick_t      pick;

    dual_ff_sync #(.DATA_WIDTH(1)) u_ack_sync (
        .clk   (clk),
        .rst_n (~rst),
        .d     (xfer_ack),
        .q     (ack_s)
    );

    assign pick      = rr_pick(RR_MAX'(in_valid), 3'(rr_ptr), NUM_REQ);
    assign g         = PW'(pick.idx);
    assign ack_match = (ack_s == xfer_req);
    assign busy      = (state == ARB_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        in_ready  = '0;
        case (state)
            ARB_IDLE: begin
                // Gated by rst so the accept strobe is also low while reset is held.
                if (pick.found && !rst) begin
                    grant       = 1'b1;
                    in_ready[g] = 1'b1;
                    state_nxt   = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (ack_match) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_data <= '0;
            xfer_id   <= '0;
            xfer_req  <= 1'b0;
            rr_ptr    <= '0;
        end else if (grant) begin
            xfer_data <= in_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
            xfer_id   <= g;
            xfer_req  <= ~xfer_req;
            rr_ptr    <= (g == P_LAST) ? '0 : g + 1'b1;
        end
    end

    // Timeout only flags; the transfer keeps waiting for the real ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer       <= '0;
            timeout_err <= 1'b0;
        end else if (grant) begin
            timer <= '0;
        end else if (state == ARB_WAIT && !ack_match) begin
            if (timer != T_MAX) begin
                timer <= timer + 1'b1;
            end
            if (timer == T_LAST) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Directed bench for cdc_tx_arbiter: a 4-requester instance (TIMEOUT=10) and a 3-requester instance.
module tb_cdc_tx_arbiter;

    logic        clk;
    logic        rst;

    logic [3:0]  in_valid_a;
    logic [31:0] in_data_a;
    logic [3:0]  in_ready_a;
    logic [7:0]  xfer_data_a;
    logic [1:0]  xfer_id_a;
    logic        xfer_req_a;
    logic        xfer_ack_a;
    logic        busy_a;
    logic        timeout_err_a;

    logic [2:0]  in_valid_b;
    logic [23:0] in_data_b;
    logic [2:0]  in_ready_b;
    logic [7:0]  xfer_data_b;
    logic [1:0]  xfer_id_b;
    logic        xfer_req_b;
    logic        xfer_ack_b;
    logic        busy_b;
    logic        timeout_err_b;

    int checks = 0;
    int errors = 0;

    cdc_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT(10)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid_a),
        .in_data     (in_data_a),
        .in_ready    (in_ready_a),
        .xfer_data   (xfer_data_a),
        .xfer_id     (xfer_id_a),
        .xfer_req    (xfer_req_a),
        .xfer_ack    (xfer_ack_a),
        .busy        (busy_a),
        .timeout_err (timeout_err_a)
    );

    cdc_tx_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .TIMEOUT(255)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid_b),
        .in_data     (in_data_b),
        .in_ready    (in_ready_b),
        .xfer_data   (xfer_data_b),
        .xfer_id     (xfer_id_b),
        .xfer_req    (xfer_req_b),
        .xfer_ack    (xfer_ack_b),
        .busy        (busy_b),
        .timeout_err (timeout_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst        = 1'b1;
        in_valid_a = '0;
        in_valid_b = '0;
        xfer_ack_a = 1'b0;
        xfer_ack_b = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid_a = 4'b1111;
        in_data_a  = 32'hDEADBEEF;
        in_valid_b = '0;
        in_data_b  = '0;
        xfer_ack_a = 1'b0;
        xfer_ack_b = 1'b0;
        repeat (3) tick();
        checks++;
        if ({in_ready_a, xfer_data_a, xfer_id_a, xfer_req_a, busy_a, timeout_err_a} !== 17'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {in_ready_a, xfer_data_a, xfer_id_a, xfer_req_a, busy_a, timeout_err_a});
        end
        in_valid_a = '0;
        rst = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || in_ready_a !== 4'b0000) begin
            errors++;
            $display("FAIL reset_release: busy %b in_ready %b required 0 / 0000", busy_a, in_ready_a);
        end
    endtask

    task automatic test_single();
        do_reset();
        in_data_a  = 32'h00A50000;
        in_valid_a = 4'b0100;
        #1;
        checks++;
        if (in_ready_a !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b required 0100", in_ready_a);
        end
        tick();
        in_valid_a = '0;
        checks++;
        if (xfer_data_a !== 8'hA5 || xfer_id_a !== 2'd2 || xfer_req_a !== 1'b1 ||
            busy_a !== 1'b1 || in_ready_a !== 4'b0000) begin
            errors++;
            $display("FAIL single_capture: data %h id %0d req %b busy %b ready %b required a5 2 1 1 0000",
                     xfer_data_a, xfer_id_a, xfer_req_a, busy_a, in_ready_a);
        end
        xfer_ack_a = 1'b1;
        repeat (2) tick();
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_2clk: got %b required 1", busy_a);
        end
        tick();
        checks++;
        if (busy_a !== 1'b0 || timeout_err_a !== 1'b0) begin
            errors++;
            $display("FAIL single_done_3clk: busy %b timeout %b required 0 0", busy_a, timeout_err_a);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_r;
        logic [1:0] exp_g;
        do_reset();
        in_data_a  = 32'h13121110;
        in_valid_a = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_g = 2'(n % 4);
            exp_r = 4'b0001 << exp_g;
            #1;
            checks++;
            if (in_ready_a !== exp_r) begin
                errors++;
                $display("FAIL rr_ready_%0d: got %b required %b", n, in_ready_a, exp_r);
            end
            tick();
            checks++;
            if (xfer_id_a !== exp_g || xfer_data_a !== (8'h10 + 8'(exp_g)) || in_ready_a !== 4'b0000) begin
                errors++;
                $display("FAIL rr_grant_%0d: id %0d data %h ready %b required %0d %h 0000",
                         n, xfer_id_a, xfer_data_a, in_ready_a, exp_g, 8'h10 + 8'(exp_g));
            end
            repeat (4) tick();
            checks++;
            if (in_ready_a !== 4'b0000 || busy_a !== 1'b1) begin
                errors++;
                $display("FAIL rr_wait_%0d: ready %b busy %b required 0000 1", n, in_ready_a, busy_a);
            end
            xfer_ack_a = ~xfer_ack_a;
            repeat (3) tick();
        end
        in_valid_a = '0;
        checks++;
        if (timeout_err_a !== 1'b0) begin
            errors++;
            $display("FAIL rr_no_timeout: got %b required 0", timeout_err_a);
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        in_data_b  = 24'h332211;
        in_valid_b = 3'b010;
        #1;
        checks++;
        if (in_ready_b !== 3'b010) begin
            errors++;
            $display("FAIL wrap_first_ready: got %b required 010", in_ready_b);
        end
        tick();
        in_valid_b = '0;
        xfer_ack_b = 1'b1;
        repeat (3) tick();
        in_valid_b = 3'b001;
        #1;
        checks++;
        if (in_ready_b !== 3'b001) begin
            errors++;
            $display("FAIL wrap_skip_ready: got %b required 001", in_ready_b);
        end
        tick();
        checks++;
        if (xfer_id_b !== 2'd0 || xfer_data_b !== 8'h11) begin
            errors++;
            $display("FAIL wrap_skip_grant: id %0d data %h required 0 11", xfer_id_b, xfer_data_b);
        end
        in_valid_b = '0;
        xfer_ack_b = 1'b0;
        repeat (3) tick();
        in_valid_b = 3'b011;
        #1;
        checks++;
        if (in_ready_b !== 3'b010) begin
            errors++;
            $display("FAIL wrap_ptr_after: got %b required 010", in_ready_b);
        end
        tick();
        in_valid_b = '0;
        xfer_ack_b = 1'b1;
        repeat (3) tick();
        in_valid_b = 3'b111;
        #1;
        checks++;
        if (in_ready_b !== 3'b100) begin
            errors++;
            $display("FAIL wrap_ptr_top: got %b required 100", in_ready_b);
        end
        tick();
        in_valid_b = '0;
        xfer_ack_b = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy_b !== 1'b0 || xfer_id_b !== 2'd2 || xfer_data_b !== 8'h33) begin
            errors++;
            $display("FAIL wrap_last: busy %b id %0d data %h required 0 2 33", busy_b, xfer_id_b, xfer_data_b);
        end
    endtask

    task automatic test_data_hold();
        do_reset();
        in_data_a  = 32'h0000003C;
        in_valid_a = 4'b0001;
        tick();
        in_data_a  = 32'h000000FF;
        in_valid_a = 4'b1110;
        repeat (2) tick();
        checks++;
        if (xfer_data_a !== 8'h3C || in_ready_a !== 4'b0000 || xfer_id_a !== 2'd0) begin
            errors++;
            $display("FAIL hold_wait: data %h ready %b id %0d required 3c 0000 0",
                     xfer_data_a, in_ready_a, xfer_id_a);
        end
        in_valid_a = '0;
        xfer_ack_a = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy_a !== 1'b0 || xfer_data_a !== 8'h3C) begin
            errors++;
            $display("FAIL hold_done: busy %b data %h required 0 3c", busy_a, xfer_data_a);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        in_data_a  = 32'h00000077;
        in_valid_a = 4'b0001;
        tick();
        in_valid_a = '0;
        repeat (9) tick();
        checks++;
        if (timeout_err_a !== 1'b0 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: err %b busy %b required 0 1", timeout_err_a, busy_a);
        end
        tick();
        checks++;
        if (timeout_err_a !== 1'b1 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set: err %b busy %b required 1 1", timeout_err_a, busy_a);
        end
        repeat (5) tick();
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL timeout_keeps_wait: busy %b required 1", busy_a);
        end
        xfer_ack_a = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy_a !== 1'b0 || timeout_err_a !== 1'b1) begin
            errors++;
            $display("FAIL timeout_late_ack: busy %b err %b required 0 1", busy_a, timeout_err_a);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        in_data_a  = 32'h0000005A;
        in_valid_a = 4'b0001;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready_a, xfer_data_a, xfer_id_a, xfer_req_a, busy_a, timeout_err_a} !== 17'h0) begin
            errors++;
            $display("FAIL midwait_async_reset: got %h required 0",
                     {in_ready_a, xfer_data_a, xfer_id_a, xfer_req_a, busy_a, timeout_err_a});
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready_a !== 4'b0001) begin
            errors++;
            $display("FAIL midwait_regrant_ready: got %b required 0001", in_ready_a);
        end
        tick();
        in_valid_a = '0;
        checks++;
        if (xfer_req_a !== 1'b1 || busy_a !== 1'b1 || xfer_id_a !== 2'd0 || xfer_data_a !== 8'h5A) begin
            errors++;
            $display("FAIL midwait_regrant: req %b busy %b id %0d data %h required 1 1 0 5a",
                     xfer_req_a, busy_a, xfer_id_a, xfer_data_a);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_data_hold();
        test_timeout();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
